// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-step shift-add MUL.
// Ports: clock/reset/flush, ID/EX ctl+data in, MEM/WB fwd in, stall + EX/MEM out.
module ex_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             regWrite_in,
  input  logic             memtoReg_in,
  input  logic             memWrite_in,
  input  logic             sb_in,
  input  logic             lh_in,
  input  logic             ld_in,
  input  logic             halt_in,
  input  logic [1:0]       ALUsrc_in,
  input  logic [3:0]       ALUop_in,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [WIDTH-1:0] readData1_in,
  input  logic [WIDTH-1:0] readData2_in,
  input  logic [WIDTH-1:0] immediate_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall,
  output logic             regWrite,
  output logic             memtoReg,
  output logic             memWrite,
  output logic             sb,
  output logic             lh,
  output logic             ld,
  output logic             halt,
  output logic [WIDTH-1:0] ALUresult,
  output logic [WIDTH-1:0] writeData,
  output logic [4:0]       rd
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [6:0]       ctrl_q, hctrl_q, ctrl_in;
  logic [WIDTH-1:0] res_q, wd_q, hwd_q;
  logic [4:0]       rd_q, hrd_q;
  logic [WIDTH-1:0] ma_q, mb_q, acc_q;
  logic [CW-1:0]    cnt_q;

  logic             ex_ok, wb_ok, mul_go;
  logic [WIDTH-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;

  assign ctrl_in = {regWrite_in, memtoReg_in, memWrite_in,
                    sb_in, lh_in, ld_in, halt_in};
  assign {regWrite, memtoReg, memWrite, sb, lh, ld, halt} = ctrl_q;
  assign ALUresult = res_q;
  assign writeData = wd_q;
  assign rd        = rd_q;

  // A load in EX/MEM has no data yet; skip it and fall through to MEM/WB.
  assign ex_ok = regWrite && !memtoReg && (rd_q != '0);
  assign wb_ok = wb_regWrite && (wb_rd != '0);

  always_comb begin
    fwd_a = readData1_in;
    if (ex_ok && rd_q == rs1_in)
      fwd_a = res_q;
    else if (wb_ok && wb_rd == rs1_in)
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = readData2_in;
    if (ex_ok && rd_q == rs2_in)
      fwd_b = res_q;
    else if (wb_ok && wb_rd == rs2_in)
      fwd_b = wb_data;
  end

  assign op_a = (ALUsrc_in == 2'd2) ? PC_in : fwd_a;
  assign op_b = (ALUsrc_in == 2'd0) ? fwd_b : immediate_in;

  always_comb begin
    alu_res = '0;
    unique case (ALUop_in)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << op_b[SW-1:0];
      4'd6:    alu_res = op_a >> op_b[SW-1:0];
      4'd7:    alu_res = $signed(op_a) >>> op_b[SW-1:0];
      4'd8:    alu_res = {{(WIDTH-1){1'b0}},
                          $signed(op_a) < $signed(op_b)};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mul_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ALUop_in == 4'd11 && !flush) begin
          stall   = 1'b1;
          mul_go  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = !flush;
        if (cnt_q == CW'(MUL_CYCLES - 1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      res_q   <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      hctrl_q <= '0;
      hwd_q   <= '0;
      hrd_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (mul_go) begin
        ma_q    <= op_a;
        mb_q    <= op_b;
        acc_q   <= '0;
        cnt_q   <= '0;
        hctrl_q <= ctrl_in;
        hrd_q   <= rd_in;
        hwd_q   <= fwd_b;
      end else if (state_q == BUSY) begin
        if (mb_q[0])
          acc_q <= acc_q + ma_q;
        ma_q  <= ma_q << 1;
        mb_q  <= mb_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
      if (flush || stall) begin
        ctrl_q <= '0;
        res_q  <= '0;
        wd_q   <= '0;
        rd_q   <= '0;
      end else if (state_q == DONE) begin
        ctrl_q <= hctrl_q;
        res_q  <= acc_q;
        wd_q   <= hwd_q;
        rd_q   <= hrd_q;
      end else begin
        ctrl_q <= ctrl_in;
        res_q  <= alu_res;
        wd_q   <= fwd_b;
        rd_q   <= rd_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: expected EX/MEM contents queued at issue,
// popped and compared when the stage registers its result.
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        regWrite_in, memtoReg_in, memWrite_in;
  logic        sb_in, lh_in, ld_in, halt_in;
  logic [1:0]  ALUsrc_in;
  logic [3:0]  ALUop_in;
  logic [31:0] PC_in, readData1_in, readData2_in, immediate_in;
  logic [4:0]  rd_in, rs1_in, rs2_in;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, regWrite, memtoReg, memWrite, sb, lh, ld, halt;
  logic [31:0] ALUresult, writeData;
  logic [4:0]  rd;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .regWrite_in(regWrite_in), .memtoReg_in(memtoReg_in),
    .memWrite_in(memWrite_in), .sb_in(sb_in), .lh_in(lh_in),
    .ld_in(ld_in), .halt_in(halt_in),
    .ALUsrc_in(ALUsrc_in), .ALUop_in(ALUop_in),
    .PC_in(PC_in), .readData1_in(readData1_in),
    .readData2_in(readData2_in), .immediate_in(immediate_in),
    .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .regWrite(regWrite), .memtoReg(memtoReg),
    .memWrite(memWrite), .sb(sb), .lh(lh), .ld(ld), .halt(halt),
    .ALUresult(ALUresult), .writeData(writeData), .rd(rd)
  );

  typedef struct packed {
    logic [95:0] nm;
    logic [31:0] res;
    logic [31:0] wd;
    logic [6:0]  ctl;
    logic [4:0]  rdv;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  src;
    logic [31:0] a, b, imm, pc;
    logic [6:0]  ctl;
    logic [31:0] res;
  } vec_t;

  exp_t        q_exp[$];
  exp_t        e;
  vec_t        tbl[15];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc, bad_rw;
  logic [6:0]  ctl_o;

  assign ctl_o = {regWrite, memtoReg, memWrite, sb, lh, ld, halt};

  function automatic exp_t mk(input logic [95:0] n,
                              input logic [31:0] r, w,
                              input logic [6:0] c,
                              input logic [4:0] d);
    exp_t t;
    t.nm = n; t.res = r; t.wd = w; t.ctl = c; t.rdv = d;
    return t;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] src,
                       input logic [31:0] a, b, imm, pc,
                       input logic [4:0] d, s1, s2,
                       input logic [6:0] c);
    ALUop_in = op; ALUsrc_in = src;
    readData1_in = a; readData2_in = b;
    immediate_in = imm; PC_in = pc;
    rd_in = d; rs1_in = s1; rs2_in = s2;
    {regWrite_in, memtoReg_in, memWrite_in,
     sb_in, lh_in, ld_in, halt_in} = c;
  endtask

  task automatic nop();
    drive(4'd0, 2'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 7'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(4'd0, 2'd0, 32'd1, 32'd2, 0, 0, 5'd5, 5'd0, 5'd0, 7'h7F);
    step(); step();
    n_cmp++;
    if ({stall, ctl_o, ALUresult, writeData, rd} !== '0) begin
      n_err++;
      $display("FAIL reset: stall=%b ctl=%b res=%h wd=%h rd=%0d, want all 0",
               stall, ctl_o, ALUresult, writeData, rd);
    end
    reset = 1'b0;
    nop();
  endtask

  task automatic test_alu();
    tbl[0]  = '{4'd0,  2'd0, 32'd7, 32'd5, 0, 0, 7'b1000000, 32'd12};
    tbl[1]  = '{4'd1,  2'd0, 32'd5, 32'd7, 0, 0, 7'b1000000, 32'hFFFFFFFE};
    tbl[2]  = '{4'd2,  2'd0, 32'hF0F0, 32'hFF00, 0, 0, 7'b1000000, 32'hF000};
    tbl[3]  = '{4'd3,  2'd0, 32'hF0F0, 32'hFF00, 0, 0, 7'b0001000, 32'hFFF0};
    tbl[4]  = '{4'd4,  2'd0, 32'hF0F0, 32'hFF00, 0, 0, 7'b0000100, 32'h0FF0};
    tbl[5]  = '{4'd5,  2'd0, 32'd1, 32'd31, 0, 0, 7'b0000010, 32'h80000000};
    tbl[6]  = '{4'd6,  2'd0, 32'h80000000, 32'd31, 0, 0, 7'b0000001, 32'd1};
    tbl[7]  = '{4'd7,  2'd0, 32'h80000000, 32'd31, 0, 0, 7'b1000000, 32'hFFFFFFFF};
    tbl[8]  = '{4'd8,  2'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 7'b1000000, 32'd0};
    tbl[9]  = '{4'd9,  2'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 7'b1000000, 32'd1};
    tbl[10] = '{4'd10, 2'd1, 32'h55, 32'h66, 32'h1234, 0, 7'b1000000, 32'h1234};
    tbl[11] = '{4'd13, 2'd0, 32'd3, 32'd4, 0, 0, 7'b1000000, 32'd0};
    tbl[12] = '{4'd0,  2'd2, 32'h999, 32'h5, 32'h8, 32'h100, 7'b1000000, 32'h108};
    tbl[13] = '{4'd0,  2'd1, 32'h200, 32'hABCD, 32'h4, 0, 7'b0010000, 32'h204};
    tbl[14] = '{4'd6,  2'd0, 32'hF0, 32'h24, 0, 0, 7'b1000000, 32'hF};
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].imm,
            tbl[i].pc, 5'(i + 1), 5'd0, 5'd0, tbl[i].ctl);
      q_exp.push_back(mk("alu", tbl[i].res, tbl[i].b, tbl[i].ctl, 5'(i + 1)));
      step();
      e = q_exp.pop_front();
      n_cmp++;
      if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
        n_err++;
        $display("FAIL %0s[%0d]: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
                 e.nm, i, ALUresult, writeData, ctl_o, rd,
                 e.res, e.wd, e.ctl, e.rdv);
      end
    end
    nop();
  endtask

  task automatic test_forwarding();
    logic [31:0] want [8];
    logic [31:0] wd   [8];
    logic [4:0]  dst  [8];
    logic [6:0]  ct   [8];
    // Producer/consumer pairs: EX wins, load skips EX, rd=0 never forwards.
    want[0] = 32'h10; wd[0] = 0;     dst[0] = 5'd3; ct[0] = 7'b1000000;
    want[1] = 32'h10; wd[1] = 0;     dst[1] = 5'd5; ct[1] = 7'b1000000;
    want[2] = 32'h10; wd[2] = 0;     dst[2] = 5'd3; ct[2] = 7'b1100000;
    want[3] = 32'h20; wd[3] = 0;     dst[3] = 5'd5; ct[3] = 7'b1000000;
    want[4] = 32'h10; wd[4] = 0;     dst[4] = 5'd0; ct[4] = 7'b1000000;
    want[5] = 32'h55; wd[5] = 0;     dst[5] = 5'd5; ct[5] = 7'b1000000;
    want[6] = 32'hCC; wd[6] = 32'h77; dst[6] = 5'd7; ct[6] = 7'b1000000;
    want[7] = 32'h0;  wd[7] = 0;     dst[7] = 5'd0; ct[7] = 7'b0000000;
    wb_regWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h20;
    for (int i = 0; i < 8; i++) begin
      unique case (i)
        0, 2, 4: drive(4'd10, 2'd1, 0, 0, 32'h10, 0, dst[i], 5'd0, 5'd0, ct[i]);
        1, 3:    drive(4'd0, 2'd1, 32'h99, 0, 0, 0, dst[i], 5'd3, 5'd0, ct[i]);
        5: begin
          wb_rd = 5'd0;
          drive(4'd0, 2'd1, 32'h55, 0, 0, 0, dst[i], 5'd0, 5'd0, ct[i]);
        end
        6: begin
          wb_rd = 5'd6; wb_data = 32'h77;
          drive(4'd0, 2'd0, 32'h1, 32'h2, 0, 0, dst[i], 5'd5, 5'd6, ct[i]);
        end
        default: begin
          wb_regWrite = 1'b0;
          nop();
        end
      endcase
      q_exp.push_back(mk("fwd", want[i], wd[i], ct[i], dst[i]));
      step();
      e = q_exp.pop_front();
      n_cmp++;
      if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
        n_err++;
        $display("FAIL %0s[%0d]: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
                 e.nm, i, ALUresult, writeData, ctl_o, rd,
                 e.res, e.wd, e.ctl, e.rdv);
      end
    end
    wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic test_mul();
    nop();
    step();
    drive(4'd11, 2'd0, 32'hFFFFFFFF, 32'd3, 0, 0, 5'd7, 5'd4, 5'd6, 7'b1000000);
    q_exp.push_back(mk("mul", 32'hFFFFFFFD, 32'd3, 7'b1000000, 5'd7));
    #1;
    cyc = 0; bad_rw = 0;
    while (stall === 1'b1 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (regWrite !== 1'b0) bad_rw++;
      if (cyc == 1) begin
        wb_regWrite = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
      end
    end
    n_cmp++;
    if (cyc !== 33) begin
      n_err++;
      $display("FAIL mul_stall_len: got %0d cycles, want 33", cyc);
    end
    n_cmp++;
    if (bad_rw !== 0) begin
      n_err++;
      $display("FAIL mul_bubble: regWrite high %0d times, want 0", bad_rw);
    end
    step();
    e = q_exp.pop_front();
    n_cmp++;
    if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
      n_err++;
      $display("FAIL %0s: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
               e.nm, ALUresult, writeData, ctl_o, rd,
               e.res, e.wd, e.ctl, e.rdv);
    end
    nop();
    wb_regWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    step();
  endtask

  task automatic test_flush();
    drive(4'd11, 2'd0, 32'd5, 32'd5, 0, 0, 5'd8, 5'd0, 5'd0, 7'b1000000);
    q_exp.push_back(mk("flush_bub", 0, 0, 7'd0, 5'd0));
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: stall=%b, want 0", stall);
    end
    step();
    e = q_exp.pop_front();
    n_cmp++;
    if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
      n_err++;
      $display("FAIL %0s: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
               e.nm, ALUresult, writeData, ctl_o, rd,
               e.res, e.wd, e.ctl, e.rdv);
    end
    flush = 1'b0;
    drive(4'd0, 2'd0, 32'd7, 32'd5, 0, 0, 5'd2, 5'd0, 5'd0, 7'b1000000);
    q_exp.push_back(mk("post_flush", 32'd12, 32'd5, 7'b1000000, 5'd2));
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL post_flush_stall: stall=%b, want 0", stall);
    end
    step();
    e = q_exp.pop_front();
    n_cmp++;
    if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
      n_err++;
      $display("FAIL %0s: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
               e.nm, ALUresult, writeData, ctl_o, rd,
               e.res, e.wd, e.ctl, e.rdv);
    end
    nop();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] p [2];
    logic [4:0]  d [2];
    a[0] = 32'd6;      b[0] = 32'd7;     p[0] = 32'd42;       d[0] = 5'd10;
    a[1] = 32'h12345;  b[1] = 32'h100;   p[1] = 32'h01234500; d[1] = 5'd0;
    for (int i = 0; i < 2; i++) begin
      drive(4'd11, 2'd0, a[i], b[i], 0, 0, d[i], 5'd13, 5'd14, 7'b1000000);
      q_exp.push_back(mk("b2b_mul", p[i], b[i], 7'b1000000, d[i]));
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_start[%0d]: stall=%b, want 1", i, stall);
      end
      cyc = 0;
      while (stall === 1'b1 && cyc < 100) begin
        @(posedge clock); #1;
        cyc++;
      end
      n_cmp++;
      if (cyc !== 33) begin
        n_err++;
        $display("FAIL b2b_len[%0d]: got %0d cycles, want 33", i, cyc);
      end
      step();
      e = q_exp.pop_front();
      n_cmp++;
      if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
        n_err++;
        $display("FAIL %0s[%0d]: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
                 e.nm, i, ALUresult, writeData, ctl_o, rd,
                 e.res, e.wd, e.ctl, e.rdv);
      end
    end
    nop();
    step();
  endtask

  task automatic test_reset_mid_mul();
    drive(4'd11, 2'd0, 32'd9, 32'd9, 0, 0, 5'd9, 5'd0, 5'd0, 7'b1000000);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    nop();
    step();
    n_cmp++;
    if ({stall, ctl_o, ALUresult, writeData, rd} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_mul: stall=%b ctl=%b res=%h rd=%0d, want all 0",
               stall, ctl_o, ALUresult, rd);
    end
    reset = 1'b0;
    drive(4'd0, 2'd0, 32'd1, 32'd1, 0, 0, 5'd1, 5'd0, 5'd0, 7'b1000000);
    q_exp.push_back(mk("post_reset", 32'd2, 32'd1, 7'b1000000, 5'd1));
    step();
    e = q_exp.pop_front();
    n_cmp++;
    if ({ALUresult, writeData, ctl_o, rd} !== {e.res, e.wd, e.ctl, e.rdv}) begin
      n_err++;
      $display("FAIL %0s: res=%h wd=%h ctl=%b rd=%0d, want res=%h wd=%h ctl=%b rd=%0d",
               e.nm, ALUresult, writeData, ctl_o, rd,
               e.res, e.wd, e.ctl, e.rdv);
    end
    nop();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_forwarding();
    test_mul();
    test_flush();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage sitting directly downstream of the ID/EX pipeline register and feeding MEM.
- Forwards operands from EX/MEM and MEM/WB.
- Runs a single-cycle ALU, plus an iterative 32-cycle shift-add multiplier that stalls the front end.
- Registers results into its own internal EX/MEM output register.

Parameters:
WIDTH, 32, datapath width
MUL_CYCLES, 32, multiplier iterations (must equal WIDTH)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all state and outputs
flush  in  1  squash instruction in EX, abort multiply
regWrite_in, memtoReg_in, memWrite_in, sb_in, lh_in, ld_in, halt_in  in  1 each  control from ID/EX
ALUsrc_in  in  2  0: B=readData2, 1: B=immediate, 2: A=PC, B=immediate
ALUop_in  in  4  operation code
PC_in, readData1_in, readData2_in, immediate_in  in  32 each  ID/EX data
rd_in, rs1_in, rs2_in  in  5 each  register indices
wb_regWrite  in  1  MEM/WB write enable
wb_rd  in  5  MEM/WB destination
wb_data  in  32  MEM/WB writeback value
stall  out  1  hold PC, IF/ID, ID/EX
regWrite, memtoReg, memWrite, sb, lh, ld, halt  out  1 each  registered EX/MEM control
ALUresult, writeData  out  32 each  registered result / store data
rd  out  5  registered destination

Behaviour:
- Clock and reset: one clock (`clock`); `reset` is synchronous and active-high, sampled on the rising edge.
- On reset, every registered output is 0 and the multiplier FSM is in IDLE.
- Forwarding applies to operand A (`rs1`) and operand B (`rs2`):
  - First choice is EX/MEM: `regWrite` && `rd` != 0 && `rd` == `rsX`; source is `ALUresult`.
  - Otherwise MEM/WB: `wb_regWrite` && `wb_rd` != 0 && `wb_rd` == `rsX`; source is `wb_data`.
  - Otherwise the `readDataX_in` value.
  - EX/MEM forwarding is disabled when EX/MEM `memtoReg`=1 (the load-use stall is upstream's job).
- `writeData` is the forwarded `rs2` value, regardless of `ALUsrc`.
- ALUop encoding (all 32-bit, wrap-around, shifts use B[4:0]):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1), 10 PASS B.
  - 11 MUL (low 32 bits of product, multi-cycle); 12-15 result 0.
- Non-MUL ops: single cycle; EX/MEM captures the result and all controls on the next edge when `stall`=0 and `flush`=0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: `stall` = (ALUop_in==11 && !flush), combinational. On that edge, latch the forwarded A and B, clear the accumulator, count=0, go to BUSY.
  - BUSY: `stall`=1. Each edge: if B[0], accumulator += A; A <<= 1; B >>= 1; count++. At count==MUL_CYCLES-1, go to DONE.
  - DONE: `stall`=0. EX/MEM captures the accumulator as `ALUresult` together with the held controls and `rd`; go to IDLE.
  - A MUL holds `stall` for exactly 33 cycles; the result appears in EX/MEM on the 34th edge after the MUL first appears in EX.
- Operands are latched at MUL start, so MEM/WB changes while stalled do not affect the product.
- While `stall`=1, EX/MEM captures a bubble: all control 0, `rd`=0; `ALUresult` and `writeData` are don't-care but driven 0.
- `flush`=1 has priority over the MUL capture and over `stall`:
  - EX/MEM captures a bubble.
  - FSM goes to IDLE from any state.
  - `stall`=0 in that cycle.
- Reset mid-multiply: FSM returns to IDLE; the partial product is discarded.
- A MUL with `rd`=0 still completes the full sequence; EX/MEM `rd`=0.
- Back-to-back MULs: the second starts from IDLE on the cycle after DONE, with no extra bubble beyond its own stall.

Test Plan:
- Reset asserted while FSM is in BUSY (cycle 10 of a MUL) -> next cycle all outputs 0, `stall`=0, FSM IDLE.
- ADD with readData1=7, readData2=5, ALUsrc=0 -> one edge later `ALUresult`=12, `regWrite` passed through; SUB 5-7 -> 0xFFFFFFFE.
- Forwarding: EX/MEM `rd`=3 with `ALUresult`=0x10, and MEM/WB `wb_rd`=3 with `wb_data`=0x20, both targeting `rs1`=3 -> A=0x10; same case with EX/MEM `memtoReg`=1 -> A=0x20; `rd`=0 -> no forward.
- MUL 0xFFFFFFFF*3 -> `stall` high for 33 cycles, 34th edge `ALUresult`=0xFFFFFFFD; EX/MEM `regWrite`=0 throughout the stall.
- `flush` at BUSY cycle 5 -> `stall` drops the same cycle, EX/MEM bubble, FSM IDLE; a following ADD executes normally.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0; ALUop 13 -> 0.
